// File: rtl/mage_loop_age.sv
// MAGE stream address generation engine: walks an affine loop nest and
// emits block-interleaved (bank, address) pairs at a programmable II.
module mage_loop_age #(
    parameter int N_LP            = 4,
    parameter int NBIT_LP_IV      = 8,
    parameter int NBIT_COEF       = 8,
    parameter int NBIT_IV_CONST   = 8,
    parameter int NBIT_FLAT_ADDR  = 10,
    parameter int N_BANKS         = 8,
    parameter int NBIT_BLOCK_SIZE = 2,
    parameter int NBIT_N_BANKS    = 2,
    parameter int NBIT_II         = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               cfg_valid_i,
    output logic                               cfg_ready_o,
    input  logic [$clog2(N_LP):0]              cfg_n_loops_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]         cfg_iv_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]         cfg_fv_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]         cfg_inc_i,
    input  logic [N_LP*NBIT_COEF-1:0]          cfg_coef_i,
    input  logic [NBIT_IV_CONST-1:0]           cfg_const_i,
    input  logic [NBIT_BLOCK_SIZE-1:0]         cfg_bs_i,
    input  logic [NBIT_N_BANKS-1:0]            cfg_nb_i,
    input  logic [$clog2(N_BANKS)-1:0]         cfg_bank_start_i,
    input  logic [NBIT_II-1:0]                 cfg_ii_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [$clog2(N_BANKS)-1:0]         out_bank_o,
    output logic [NBIT_FLAT_ADDR-1:0]          out_addr_o,
    output logic                               out_last_o,
    output logic                               busy_o,
    output logic                               done_o
);
    localparam int NLW = $clog2(N_LP) + 1;
    localparam int BW  = $clog2(N_BANKS);
    localparam int FW  = NBIT_FLAT_ADDR;
    localparam int PW  = NBIT_COEF + NBIT_LP_IV;

    typedef logic [N_LP-1:0][NBIT_LP_IV-1:0] iv_vec_t;
    typedef logic [N_LP-1:0][NBIT_COEF-1:0]  coef_vec_t;
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t                     state_q;
    logic [NLW-1:0]             nl_q;
    iv_vec_t                    iv0_q, fv_q, inc_q, iv_q;
    coef_vec_t                  coef_q;
    logic [NBIT_IV_CONST-1:0]   const_q;
    logic [NBIT_BLOCK_SIZE-1:0] bs_q;
    logic [NBIT_N_BANKS-1:0]    nb_q;
    logic [BW-1:0]              bank0_q, bank_q;
    logic [NBIT_II-1:0]         ii_q, wcnt_q;
    logic [FW-1:0]              addr_q;
    logic                       valid_q, last_q, done_q;

    int                         n_act;
    iv_vec_t                    src_iv;
    logic                       src_last;
    logic [FW-1:0]              flat, sel, bs_mask, nb_mask, addr_n;
    logic [BW-1:0]              bank_n;
    logic [7:0]                 shamt;

    // Loop step is done at one bit wider than iv so iv+inc never overflows.
    function automatic logic [NBIT_LP_IV:0] lp_sum(input iv_vec_t v, input int l);
        logic [NBIT_LP_IV:0] inc_e;
        inc_e = {1'b0, inc_q[l]};
        if (inc_q[l] == '0) inc_e = (NBIT_LP_IV+1)'(1);
        return {1'b0, v[l]} + inc_e;
    endfunction

    function automatic iv_vec_t adv(input iv_vec_t v, input int na);
        iv_vec_t             nv;
        logic                c;
        logic [NBIT_LP_IV:0] s;
        nv = v;
        c  = 1'b1;
        for (int l = 0; l < N_LP; l++) begin
            s = lp_sum(v, l);
            if (c && l < na) begin
                if (s > {1'b0, fv_q[l]}) begin
                    nv[l] = iv0_q[l];
                end else begin
                    nv[l] = s[NBIT_LP_IV-1:0];
                    c     = 1'b0;
                end
            end
        end
        return nv;
    endfunction

    function automatic logic all_wrap(input iv_vec_t v, input int na);
        logic w;
        w = 1'b1;
        for (int l = 0; l < N_LP; l++) begin
            if (l < na && !(lp_sum(v, l) > {1'b0, fv_q[l]})) w = 1'b0;
        end
        return w;
    endfunction

    always_comb begin
        if (nl_q == '0)               n_act = 1;
        else if (int'(nl_q) > N_LP)   n_act = N_LP;
        else                          n_act = int'(nl_q);
    end

    // The next iteration to present: the initial point on start, else the successor.
    always_comb begin
        src_iv   = (state_q == IDLE) ? iv0_q : adv(iv_q, n_act);
        src_last = all_wrap(src_iv, n_act);
        flat     = FW'(const_q);
        for (int l = 0; l < N_LP; l++) begin
            if (l < n_act)
                flat = flat + FW'(PW'(coef_q[l]) * PW'(src_iv[l]));
        end
        shamt   = 8'(bs_q) + 8'(nb_q);
        bs_mask = ~({FW{1'b1}} << bs_q);
        nb_mask = ~({FW{1'b1}} << nb_q);
        sel     = flat >> bs_q;
        bank_n  = bank0_q + BW'(sel & nb_mask);
        addr_n  = ((flat >> shamt) << bs_q) | (flat & bs_mask);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            nl_q    <= '0;
            iv0_q   <= '0;
            fv_q    <= '0;
            inc_q   <= '0;
            iv_q    <= '0;
            coef_q  <= '0;
            const_q <= '0;
            bs_q    <= '0;
            nb_q    <= '0;
            bank0_q <= '0;
            ii_q    <= '0;
            wcnt_q  <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cfg_valid_i) begin
                            nl_q    <= cfg_n_loops_i;
                            iv0_q   <= cfg_iv_i;
                            fv_q    <= cfg_fv_i;
                            inc_q   <= cfg_inc_i;
                            coef_q  <= cfg_coef_i;
                            const_q <= cfg_const_i;
                            bs_q    <= cfg_bs_i;
                            nb_q    <= cfg_nb_i;
                            bank0_q <= cfg_bank_start_i;
                            ii_q    <= cfg_ii_i;
                        end
                        if (start_i) begin
                            state_q <= RUN;
                            iv_q    <= src_iv;
                            bank_q  <= bank_n;
                            addr_q  <= addr_n;
                            last_q  <= src_last;
                            valid_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (out_ready_i) begin
                            if (last_q) begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                iv_q   <= src_iv;
                                bank_q <= bank_n;
                                addr_q <= addr_n;
                                last_q <= src_last;
                                if (ii_q > NBIT_II'(1)) begin
                                    state_q <= WAIT;
                                    valid_q <= 1'b0;
                                    wcnt_q  <= ii_q - NBIT_II'(2);
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (wcnt_q == '0) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q - NBIT_II'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = valid_q;
    assign out_bank_o  = bank_q;
    assign out_addr_o  = addr_q;
    assign out_last_o  = last_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mage_loop_age.sv
// Bench for mage_loop_age: nested-loop reference model feeds a scoreboard
// that is drained on every accepted beat.
module tb_mage_loop_age;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_n_loops = '0;
    logic [31:0] cfg_iv = '0, cfg_fv = '0, cfg_inc = '0, cfg_coef = '0;
    logic [7:0]  cfg_const = '0;
    logic [1:0]  cfg_bs = '0, cfg_nb = '0;
    logic [2:0]  cfg_bank_start = '0;
    logic [3:0]  cfg_ii = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic        out_valid, out_ready = 1'b0, out_last, busy, done;
    logic [2:0]  out_bank;
    logic [9:0]  out_addr;

    mage_loop_age dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_n_loops_i(cfg_n_loops), .cfg_iv_i(cfg_iv), .cfg_fv_i(cfg_fv),
        .cfg_inc_i(cfg_inc), .cfg_coef_i(cfg_coef), .cfg_const_i(cfg_const),
        .cfg_bs_i(cfg_bs), .cfg_nb_i(cfg_nb), .cfg_bank_start_i(cfg_bank_start),
        .cfg_ii_i(cfg_ii), .start_i(start), .abort_i(abort),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_bank_o(out_bank), .out_addr_o(out_addr), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    logic [13:0] exp_q[$];
    int beat_cyc[$];
    int done_cnt, done_cyc, valid_cnt;

    int m_nl, m_const, m_bs, m_nb, m_bank0, m_ii;
    int m_iv[4], m_fv[4], m_inc[4], m_coef[4];

    // Sample at the falling edge, then return 1 ns after the next rising edge.
    task automatic tick();
        logic [13:0] e;
        @(negedge clk);
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready) begin
            beat_cyc.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat_unexpected: got bank=%0d addr=%0d last=%0d, want no beat",
                         out_bank, out_addr, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_bank, out_addr} !== e) begin
                    n_bad++;
                    $display("FAIL beat: got last=%0d bank=%0d addr=%0d, want last=%0d bank=%0d addr=%0d",
                             out_last, out_bank, out_addr, e[13], e[12:10], e[9:0]);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic zero_model();
        m_nl = 0; m_const = 0; m_bs = 0; m_nb = 0; m_bank0 = 0; m_ii = 0;
        for (int l = 0; l < 4; l++) begin
            m_iv[l] = 0; m_fv[l] = 0; m_inc[l] = 0; m_coef[l] = 0;
        end
    endtask

    task automatic drive_cfg();
        cfg_n_loops = 3'(m_nl);
        for (int l = 0; l < 4; l++) begin
            cfg_iv[l*8 +: 8]   = 8'(m_iv[l]);
            cfg_fv[l*8 +: 8]   = 8'(m_fv[l]);
            cfg_inc[l*8 +: 8]  = 8'(m_inc[l]);
            cfg_coef[l*8 +: 8] = 8'(m_coef[l]);
        end
        cfg_const = 8'(m_const);
        cfg_bs = 2'(m_bs);
        cfg_nb = 2'(m_nb);
        cfg_bank_start = 3'(m_bank0);
        cfg_ii = 4'(m_ii);
    endtask

    task automatic apply_cfg();
        drive_cfg();
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [13:0] model_entry(int v0, int v1, int v2, int v3, int nl);
        int flat, bank, addr;
        flat = m_const;
        if (nl > 0) flat += m_coef[0] * v0;
        if (nl > 1) flat += m_coef[1] * v1;
        if (nl > 2) flat += m_coef[2] * v2;
        if (nl > 3) flat += m_coef[3] * v3;
        flat = flat & 1023;
        bank = (m_bank0 + ((flat >> m_bs) & ((1 << m_nb) - 1))) % 8;
        addr = (((flat >> (m_bs + m_nb)) << m_bs) | (flat & ((1 << m_bs) - 1))) & 1023;
        return {1'b0, 3'(bank), 10'(addr)};
    endfunction

    task automatic push_model();
        int nl, v0, v1, v2, v3;
        int inc[4];
        logic [13:0] e;
        nl = (m_nl == 0) ? 1 : (m_nl > 4 ? 4 : m_nl);
        for (int l = 0; l < 4; l++) inc[l] = (m_inc[l] == 0) ? 1 : m_inc[l];
        v3 = m_iv[3];
        do begin
            v2 = m_iv[2];
            do begin
                v1 = m_iv[1];
                do begin
                    v0 = m_iv[0];
                    do begin
                        exp_q.push_back(model_entry(v0, v1, v2, v3, nl));
                        v0 += inc[0];
                    end while (v0 <= m_fv[0]);
                    v1 += inc[1];
                end while (nl > 1 && v1 <= m_fv[1]);
                v2 += inc[2];
            end while (nl > 2 && v2 <= m_fv[2]);
            v3 += inc[3];
        end while (nl > 3 && v3 <= m_fv[3]);
        e = exp_q.pop_back();
        e[13] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic clear_obs();
        beat_cyc.delete();
        valid_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int s;
        bit ok;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({cfg_ready, out_valid, busy, done, out_last} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 10000", {cfg_ready, out_valid, busy, done, out_last});
        end
        n_cmp++;
        if ({out_bank, out_addr} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_data: got bank=%0d addr=%0d want 0/0", out_bank, out_addr);
        end
        rst_n = 1'b1;
        tick();
        zero_model();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(20, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 1) begin
            n_bad++;
            $display("FAIL reset_cfg_walk: got done=%0d beats=%0d want 1/1", ok, beat_cyc.size());
        end
    endtask

    task automatic test_single_loop();
        int s;
        bit ok;
        zero_model();
        m_nl = 1; m_fv[0] = 3; m_inc[0] = 1; m_coef[0] = 1; m_bank0 = 2; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(40, ok);
        tick();
        tick();
        n_cmp++;
        if (!ok || beat_cyc.size() != 4) begin
            n_bad++;
            $display("FAIL single_count: got done=%0d beats=%0d want 1/4", ok, beat_cyc.size());
        end else begin
            n_cmp++;
            if (beat_cyc[0] != s + 1) begin
                n_bad++;
                $display("FAIL single_latency: got cyc %0d want %0d", beat_cyc[0], s + 1);
            end
            n_cmp++;
            if (beat_cyc[3] - beat_cyc[0] != 3) begin
                n_bad++;
                $display("FAIL single_b2b: got span %0d want 3", beat_cyc[3] - beat_cyc[0]);
            end
            n_cmp++;
            if (done_cyc != beat_cyc[3] + 1 || done_cnt != 1) begin
                n_bad++;
                $display("FAIL single_done: got cyc %0d cnt %0d want cyc %0d cnt 1",
                         done_cyc, done_cnt, beat_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_two_loops();
        int s;
        bit ok;
        zero_model();
        m_nl = 2; m_fv[0] = 1; m_inc[0] = 1; m_coef[0] = 1;
        m_fv[1] = 2; m_inc[1] = 1; m_coef[1] = 4; m_const = 5; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(40, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 6 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL two_loops: got done=%0d beats=%0d left=%0d want 1/6/0",
                     ok, beat_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_bank_map();
        int s;
        bit ok;
        zero_model();
        m_nl = 1; m_fv[0] = 7; m_inc[0] = 1; m_coef[0] = 1;
        m_bs = 1; m_nb = 2; m_bank0 = 6; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(40, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 8 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bank_map: got done=%0d beats=%0d left=%0d want 1/8/0",
                     ok, beat_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_ii();
        int s;
        bit ok;
        zero_model();
        m_nl = 1; m_fv[0] = 2; m_inc[0] = 1; m_coef[0] = 3; m_const = 1; m_ii = 3;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(40, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL ii_count: got done=%0d beats=%0d want 1/3", ok, beat_cyc.size());
        end else begin
            n_cmp++;
            if (beat_cyc[1] - beat_cyc[0] != 3 || beat_cyc[2] - beat_cyc[1] != 3) begin
                n_bad++;
                $display("FAIL ii_spacing: got %0d,%0d want 3,3",
                         beat_cyc[1] - beat_cyc[0], beat_cyc[2] - beat_cyc[1]);
            end
            n_cmp++;
            if (valid_cnt != 3) begin
                n_bad++;
                $display("FAIL ii_valid_low: got %0d valid cycles want 3", valid_cnt);
            end
        end
    endtask

    task automatic test_stall();
        int s;
        bit ok;
        zero_model();
        m_nl = 1; m_fv[0] = 5; m_inc[0] = 1; m_coef[0] = 2; m_bank0 = 1; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b0;
        pulse_start(s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || {out_last, out_bank, out_addr} !== exp_q[0]) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%0d bank=%0d addr=%0d want v=1 bank=%0d addr=%0d",
                         k, out_valid, out_bank, out_addr, exp_q[0][12:10], exp_q[0][9:0]);
            end
            tick();
        end
        out_ready = 1'b1;
        run_to_done(40, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 6 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_resume: got done=%0d beats=%0d left=%0d want 1/6/0",
                     ok, beat_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_abort();
        int s;
        bit ok;
        zero_model();
        m_nl = 1; m_fv[0] = 5; m_inc[0] = 1; m_coef[0] = 1; m_const = 9; m_bank0 = 3; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b0;
        pulse_start(s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_cfg_ready: got %0d want 0", cfg_ready);
        end
        cfg_const = 8'd100;
        cfg_bank_start = 3'd0;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({out_valid, busy, cfg_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL abort_state: got v/busy/rdy=%b want 001", {out_valid, busy, cfg_ready});
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
        end
        exp_q.delete();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        run_to_done(40, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 6 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_replay: got done=%0d beats=%0d left=%0d want 1/6/0",
                     ok, beat_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        zero_model();
        m_nl = 2; m_fv[0] = 3; m_inc[0] = 1; m_coef[0] = 1;
        m_fv[1] = 3; m_inc[1] = 1; m_coef[1] = 8; m_const = 37; m_bank0 = 5; m_ii = 1;
        apply_cfg();
        clear_obs();
        push_model();
        out_ready = 1'b1;
        pulse_start(s);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cfg_ready, out_valid, busy, done, out_last, out_bank, out_addr} !== {5'b10000, 13'd0}) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy/v/busy/done/last=%b bank=%0d addr=%0d want 10000/0/0",
                     {cfg_ready, out_valid, busy, done, out_last}, out_bank, out_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        zero_model();
        clear_obs();
        push_model();
        pulse_start(s);
        run_to_done(20, ok);
        n_cmp++;
        if (!ok || beat_cyc.size() != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid_cfg_cleared: got done=%0d beats=%0d left=%0d want 1/1/0",
                     ok, beat_cyc.size(), exp_q.size());
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_single_loop();
        test_two_loops();
        test_bank_map();
        test_ii();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mage_loop_age.md
Name: mage_loop_age

Overview:
- Parametrised next-generation address generation engine (AGE) for one MAGE stream.
- Walks a configurable-depth affine loop nest and computes the flat address as const plus the sum of coef times iv.
- Maps each flat address onto block-interleaved banks and emits one (bank, address) pair per iteration over a valid/ready handshake.
- Iterations are paced by a programmable initiation interval. Sits between the stream configuration memory and the bank crossbar.

Parameters:
- N_LP, 4, maximum loop-nest depth (1..8)
- NBIT_LP_IV, 8, width of iv/fv/inc per loop
- NBIT_COEF, 8, unsigned per-loop stride coefficient width
- NBIT_IV_CONST, 8, subscript constant width
- NBIT_FLAT_ADDR, 10, flat address width; arithmetic wraps modulo 2^NBIT_FLAT_ADDR
- N_BANKS, 8, banks reachable (power of two)
- NBIT_BLOCK_SIZE, 2, block-size field width (block = 2^bs words)
- NBIT_N_BANKS, 2, log2 of interleave bank count
- NBIT_II, 4, initiation-interval width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  configuration present
- cfg_ready_o  out  1  high only in IDLE
- cfg_n_loops_i  in  $clog2(N_LP)+1  active loops, 0 treated as 1
- cfg_iv_i / cfg_fv_i / cfg_inc_i  in  N_LP*NBIT_LP_IV each  per-loop init/final/increment; loop 0 innermost
- cfg_coef_i  in  N_LP*NBIT_COEF  per-loop stride
- cfg_const_i  in  NBIT_IV_CONST  constant
- cfg_bs_i  in  NBIT_BLOCK_SIZE  log2 block size
- cfg_nb_i  in  NBIT_N_BANKS  log2 banks used
- cfg_bank_start_i  in  $clog2(N_BANKS)  first bank
- cfg_ii_i  in  NBIT_II  initiation interval, 0 treated as 1
- start_i  in  1  begin walk
- abort_i  in  1  terminate walk
- out_valid_o  out  1  address valid
- out_ready_i  in  1  consumer accepts
- out_bank_o  out  $clog2(N_BANKS)  target bank
- out_addr_o  out  NBIT_FLAT_ADDR  in-bank address
- out_last_o  out  1  final iteration
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse after the last transfer

Behaviour:
- Reset values: state IDLE; all counters and config registers 0; cfg_ready_o=1; out_valid_o, out_last_o, busy_o, done_o = 0; out_bank_o=0; out_addr_o=0.
- States:
  - IDLE: config is captured on cfg_valid_i && cfg_ready_o. start_i moves the engine to RUN and loads iv counters from the captured cfg_iv. start_i without a prior capture uses the reset configuration, which is all zeros and produces one iteration.
  - RUN: drives out_valid_o.
  - WAIT: II spacing.
- Output is registered. out_valid_o rises the cycle after start_i is sampled.
- out_valid_o holds, and bank/addr/last stay stable, until out_ready_i. No combinational path from ready to valid.
- Handshake fires, not last, ii=1: the counters advance and out_valid_o stays high with the next iteration the following cycle.
- Handshake fires, not last, ii>1: go to WAIT for ii-1 cycles with out_valid_o=0, then return to RUN with the next iteration.
- Handshake fires on last: go to IDLE and pulse done_o the next cycle.
- Counter advance rules:
  - Loop 0 steps by inc. Comparisons use NBIT_LP_IV+1 bits, so there is no overflow.
  - If iv+inc > fv, loop 0 reloads its init value and carries into loop 1, and so on up the nest.
  - A carry out of loop n_loops-1 means the walk is complete.
  - inc=0 is treated as 1.
  - iv>fv at load means that loop runs once.
- out_last_o: asserted when every active loop would wrap on its next increment.
- Flat address: flat = const + sum over active loops of coef[l]*iv[l], truncated to NBIT_FLAT_ADDR. Inactive loops contribute 0. Computed from the next-iteration counters and registered with the output.
- Bank mapping:
  - bank = (bank_start + ((flat >> bs) & (2^nb-1))) mod N_BANKS
  - addr = ((flat >> (bs+nb)) << bs) | (flat & (2^bs-1))
- abort_i, any state: IDLE next cycle, out_valid_o=0, no done_o. abort_i takes priority over a simultaneous handshake.
- start_i outside IDLE is ignored. cfg_valid_i outside IDLE is not accepted.
- busy_o=1 in RUN and WAIT.
- Reset asserted mid-walk forces all outputs to their reset values immediately (asynchronous). The captured config is also cleared.

Test Plan:
- 1 loop, iv=0 fv=3 inc=1, coef=1, const=0, bs=0, nb=0, bank_start=2, ii=1, ready tied high -> 4 back-to-back beats: bank 2, addr 0,1,2,3; last on the 4th beat; done_o one cycle after.
- 2 loops, loop0 iv=0 fv=1 inc=1 coef=1, loop1 iv=0 fv=2 inc=1 coef=4, const=5, nb=0 -> flat sequence 5,6,9,10,13,14; last on 14.
- 1 loop, fv=7, coef=1, bs=1, nb=2, bank_start=6 -> (bank,addr) = (6,0),(6,1),(7,0),(7,1),(0,0),(0,1),(1,0),(1,1).
- ii=3, 3 iterations, ready high -> valid beats at cycles t, t+3, t+6; valid low in between.
- Ready held low 5 cycles on beat 2 -> valid, bank and addr stable for all 5 cycles; the sequence resumes unchanged.
- abort_i on beat 2 of 6 -> valid low next cycle; busy_o=0; no done_o. New start_i replays from iteration 0. Also: cfg_valid_i while busy is ignored, and reset mid-walk zeroes all outputs.
